// File: rtl/fsb_master_if.sv
// Fast system bus signal bundle between initiator and responder.
// Master drives address/strobes/data-out; slave drives data-in and terminations.
interface fsb_master_if;
    logic [2:0]  FC;
    logic [22:0] A;
    logic        RnW;
    logic        nAS;
    logic        nUDS;
    logic        nLDS;
    logic [15:0] DOut;
    logic        DOE;
    logic [15:0] DIn;
    logic        nDTACK;
    logic        nVPA;
    logic        nBERR;

    modport master (
        output FC, A, RnW, nAS, nUDS, nLDS, DOut, DOE,
        input  DIn, nDTACK, nVPA, nBERR
    );

    modport slave (
        input  FC, A, RnW, nAS, nUDS, nLDS, DOut, DOE,
        output DIn, nDTACK, nVPA, nBERR
    );
endinterface

// File: rtl/fsb_master.sv
// Fast system bus initiator: turns one client word request into a bus cycle.
// Ports: FCLK/Reset; client Req/Write/ReqFC/ReqA/ReqBE/WrData in,
// RdData/Done/Err/Avec/Busy out; bus = fsb_master_if master modport.
module fsb_master #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        FCLK,
    input  logic        Reset,
    input  logic        Req,
    input  logic        Write,
    input  logic [2:0]  ReqFC,
    input  logic [22:0] ReqA,
    input  logic [1:0]  ReqBE,
    input  logic [15:0] WrData,
    output logic [15:0] RdData,
    output logic        Done,
    output logic        Err,
    output logic        Avec,
    output logic        Busy,
    fsb_master_if.master bus
);
    typedef enum logic [2:0] {
        IDLE, S1, S2, WAIT, TERM, REC
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_fc;
    logic [22:0] r_a;
    logic        r_rnw;
    logic [1:0]  r_be;
    logic [15:0] r_wdata;
    logic [15:0] r_rddata;
    logic        r_err;
    logic        r_avec;
    logic        r_armed;
    logic [7:0]  r_wd;

    logic w_accept;
    logic w_smp;
    logic w_berr;
    logic w_dtack;
    logic w_vpa;
    logic w_tmo;
    logic w_term;
    logic w_nas;
    logic w_nuds;
    logic w_nlds;
    logic w_doe;
    logic w_done;
    logic w_busy;

    // Only start once the previous responder has let go of all terminations.
    assign w_accept = Req & bus.nDTACK & bus.nVPA & bus.nBERR;
    // First WAIT cycle is never sampled, so early terminations are held off.
    assign w_smp    = (r_state == WAIT) & r_armed;
    assign w_berr   = ~bus.nBERR;
    assign w_dtack  = ~bus.nDTACK;
    assign w_vpa    = ~bus.nVPA;
    assign w_tmo    = (r_wd == 8'(TIMEOUT));
    assign w_term   = w_smp & (w_berr | w_dtack | w_vpa | w_tmo);

    always_ff @(posedge FCLK) begin
        if (Reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_nas  = 1'b1;
        w_nuds = 1'b1;
        w_nlds = 1'b1;
        w_doe  = 1'b0;
        w_done = 1'b0;
        w_busy = 1'b1;
        unique case (r_state)
            IDLE: begin
                w_busy = 1'b0;
                if (w_accept) w_next = S1;
            end
            S1: begin
                w_doe  = ~r_rnw;
                w_next = S2;
            end
            S2: begin
                w_nas = 1'b0;
                w_doe = ~r_rnw;
                // Reads strobe with nAS; writes wait for data to settle.
                if (r_rnw) begin
                    w_nuds = ~r_be[1];
                    w_nlds = ~r_be[0];
                end
                w_next = WAIT;
            end
            WAIT: begin
                w_nas  = 1'b0;
                w_doe  = ~r_rnw;
                w_nuds = ~r_be[1];
                w_nlds = ~r_be[0];
                if (w_term) w_next = TERM;
            end
            TERM: begin
                w_done = 1'b1;
                w_next = REC;
            end
            REC: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge FCLK) begin
        if (Reset) begin
            r_fc     <= '0;
            r_a      <= '0;
            r_rnw    <= 1'b1;
            r_be     <= 2'b11;
            r_wdata  <= '0;
            r_rddata <= '0;
            r_err    <= 1'b0;
            r_avec   <= 1'b0;
            r_armed  <= 1'b0;
            r_wd     <= '0;
        end else begin
            r_armed <= (r_state == WAIT);
            if (r_state == IDLE && w_accept) begin
                r_fc    <= ReqFC;
                r_a     <= ReqA;
                r_rnw   <= ~Write;
                r_be    <= (ReqBE == 2'b00) ? 2'b11 : ReqBE;
                r_wdata <= WrData;
            end
            if (r_state == S2) r_wd <= '0;
            if (w_smp) begin
                if (w_berr) begin
                    r_err <= 1'b1;
                end else if (w_dtack) begin
                    if (r_rnw) r_rddata <= bus.DIn;
                end else if (w_vpa) begin
                    r_avec <= 1'b1;
                end else if (w_tmo) begin
                    r_err <= 1'b1;
                end else if (r_wd != 8'hFF) begin
                    r_wd <= r_wd + 8'd1;
                end
            end
            if (r_state == TERM) begin
                r_err  <= 1'b0;
                r_avec <= 1'b0;
            end
            if (r_state == REC) r_rnw <= 1'b1;
        end
    end

    assign bus.FC   = r_fc;
    assign bus.A    = r_a;
    assign bus.RnW  = r_rnw;
    assign bus.nAS  = w_nas;
    assign bus.nUDS = w_nuds;
    assign bus.nLDS = w_nlds;
    assign bus.DOut = r_wdata;
    assign bus.DOE  = w_doe;

    assign RdData = r_rddata;
    assign Done   = w_done;
    assign Err    = r_err;
    assign Avec   = r_avec;
    assign Busy   = w_busy;
endmodule

// File: tb/tb_fsb_master.sv
// Bench for fsb_master: acts as bus responder and checks every cycle
// against a transaction-level model of outcome, timing and strobes.
module tb_fsb_master;
    localparam int TO = 4;

    logic        FCLK = 1'b0;
    logic        Reset;
    logic        Req;
    logic        Write;
    logic [2:0]  ReqFC;
    logic [22:0] ReqA;
    logic [1:0]  ReqBE;
    logic [15:0] WrData;
    logic [15:0] RdData;
    logic        Done;
    logic        Err;
    logic        Avec;
    logic        Busy;

    fsb_master_if bus();

    fsb_master #(.TIMEOUT(TO)) dut (
        .FCLK   (FCLK),
        .Reset  (Reset),
        .Req    (Req),
        .Write  (Write),
        .ReqFC  (ReqFC),
        .ReqA   (ReqA),
        .ReqBE  (ReqBE),
        .WrData (WrData),
        .RdData (RdData),
        .Done   (Done),
        .Err    (Err),
        .Avec   (Avec),
        .Busy   (Busy),
        .bus    (bus.master)
    );

    always #5 FCLK = ~FCLK;

    int n_vec = 0;
    int n_err = 0;
    logic [15:0] m_rd = 16'h0;

    localparam int K_DTACK = 0;
    localparam int K_VPA   = 1;
    localparam int K_BERR  = 2;
    localparam int K_BOTH  = 3;
    localparam int K_NONE  = 4;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_term(input int kind);
        bus.nBERR  = !(kind == K_BERR || kind == K_BOTH);
        bus.nDTACK = !(kind == K_DTACK || kind == K_BOTH);
        bus.nVPA   = !(kind == K_VPA);
    endtask

    // One full bus cycle. Called at a negedge; values driven at negedge
    // c are sampled by the DUT at edge t+c (t = accept edge).
    task automatic xfer(input bit wr, input logic [2:0] fc,
                        input logic [22:0] a, input logic [1:0] be,
                        input logic [15:0] wd, input int kind,
                        input int waits, input bit early,
                        input logic [15:0] din, input bit hold);
        logic [1:0] ebe;
        int done_c;
        int drv_c;
        int g;
        bit e_err;
        bit e_avec;
        logic [15:0] e_rd;
        bit act;
        ebe = (be == 2'b00) ? 2'b11 : be;
        e_rd = m_rd;
        if (kind == K_NONE || waits > TO) begin
            done_c = 5 + TO;
            e_err  = 1'b1;
            e_avec = 1'b0;
        end else begin
            done_c = early ? 5 : 5 + waits;
            e_err  = (kind == K_BERR || kind == K_BOTH);
            e_avec = (kind == K_VPA);
            if (kind == K_DTACK && !wr) e_rd = din;
        end
        drv_c = early ? 2 : 4 + waits;
        set_term(K_NONE);
        bus.DIn = din;
        Write = wr;
        ReqFC = fc;
        ReqA = a;
        ReqBE = be;
        WrData = wd;
        Req = 1'b1;
        g = 0;
        do begin
            @(negedge FCLK);
            g++;
        end while (!Busy && g < 20);
        chk("accept", {31'd0, Busy}, 32'd1);
        if (!Busy) begin
            Req = 1'b0;
            return;
        end
        Req = 1'b0;
        for (int c = 1; c <= done_c + 2; c++) begin
            if (c > 1) @(negedge FCLK);
            chk($sformatf("busy c%0d", c), {31'd0, Busy},
                {31'd0, c <= done_c + 1});
            chk($sformatf("done c%0d", c), {31'd0, Done},
                {31'd0, c == done_c});
            chk($sformatf("nAS c%0d", c), {31'd0, bus.nAS},
                {31'd0, !(c >= 2 && c < done_c)});
            act = (c < done_c) && (wr ? c >= 3 : c >= 2);
            chk($sformatf("nUDS c%0d", c), {31'd0, bus.nUDS},
                {31'd0, !(act && ebe[1])});
            chk($sformatf("nLDS c%0d", c), {31'd0, bus.nLDS},
                {31'd0, !(act && ebe[0])});
            chk($sformatf("DOE c%0d", c), {31'd0, bus.DOE},
                {31'd0, wr && c < done_c});
            if (c == 1 || c == done_c + 1) begin
                chk("FC", {29'd0, bus.FC}, {29'd0, fc});
                chk("A", {9'd0, bus.A}, {9'd0, a});
            end
            if (c == 1) begin
                chk("RnW", {31'd0, bus.RnW}, {31'd0, !wr});
                if (wr) chk("DOut", {16'd0, bus.DOut}, {16'd0, wd});
            end
            if (c == done_c) begin
                chk("Err", {31'd0, Err}, {31'd0, e_err});
                chk("Avec", {31'd0, Avec}, {31'd0, e_avec});
                chk("RdData", {16'd0, RdData}, {16'd0, e_rd});
                if (!hold) set_term(K_NONE);
            end
            if (c == done_c + 1) begin
                chk("Err clr", {31'd0, Err}, 32'd0);
                chk("Avec clr", {31'd0, Avec}, 32'd0);
            end
            if (c == drv_c && kind != K_NONE && c < done_c)
                set_term(kind);
        end
        m_rd = e_rd;
    endtask

    initial begin
        Reset = 1'b1;
        Req = 1'b0;
        Write = 1'b0;
        ReqFC = '0;
        ReqA = '0;
        ReqBE = '0;
        WrData = '0;
        bus.DIn = '0;
        set_term(K_NONE);
        repeat (3) @(negedge FCLK);
        chk("rst nAS", {31'd0, bus.nAS}, 32'd1);
        chk("rst nUDS", {31'd0, bus.nUDS}, 32'd1);
        chk("rst nLDS", {31'd0, bus.nLDS}, 32'd1);
        chk("rst RnW", {31'd0, bus.RnW}, 32'd1);
        chk("rst DOE", {31'd0, bus.DOE}, 32'd0);
        chk("rst Done", {31'd0, Done}, 32'd0);
        chk("rst Err", {31'd0, Err}, 32'd0);
        chk("rst Avec", {31'd0, Avec}, 32'd0);
        chk("rst Busy", {31'd0, Busy}, 32'd0);
        chk("rst FC", {29'd0, bus.FC}, 32'd0);
        chk("rst A", {9'd0, bus.A}, 32'd0);
        chk("rst RdData", {16'd0, RdData}, 32'd0);
        Reset = 1'b0;
        @(negedge FCLK);

        xfer(0, 3'b101, 23'(32'h123456 >> 1), 2'b11, 16'h0,
             K_DTACK, 0, 0, 16'hBEEF, 0);
        xfer(1, 3'b001, 23'h0ABCDE, 2'b10, 16'h55AA,
             K_DTACK, 3, 0, 16'h9999, 0);
        xfer(0, 3'b010, 23'h000100, 2'b01, 16'h0,
             K_NONE, 0, 0, 16'h7777, 0);
        xfer(0, 3'b110, 23'h3FFFFF, 2'b11, 16'h0,
             K_BOTH, 1, 0, 16'h1234, 0);
        xfer(0, 3'b111, 23'h7FFFFF, 2'b11, 16'h0,
             K_VPA, 0, 0, 16'hCAFE, 0);
        xfer(0, 3'b101, 23'h000042, 2'b00, 16'h0,
             K_DTACK, 0, 1, 16'hA5A5, 0);

        xfer(0, 3'b001, 23'h001234, 2'b11, 16'h0,
             K_DTACK, 2, 0, 16'h4321, 1);
        Req = 1'b1;
        repeat (4) begin
            @(negedge FCLK);
            chk("hold noacc", {31'd0, Busy}, 32'd0);
        end
        Req = 1'b0;
        xfer(1, 3'b010, 23'h055555, 2'b01, 16'h0F0F,
             K_DTACK, 0, 0, 16'h1111, 0);

        for (int i = 0; i < 24; i++) begin
            bit wr;
            int kind;
            int waits;
            bit early;
            wr = 1'($urandom_range(0, 1));
            kind = $urandom_range(0, 4);
            waits = $urandom_range(0, 3);
            early = (kind != K_NONE) && ($urandom_range(0, 3) == 0);
            xfer(wr, 3'($urandom), 23'($urandom), 2'($urandom),
                 16'($urandom), kind, waits, early, 16'($urandom), 0);
        end

        set_term(K_NONE);
        Write = 1'b0;
        ReqBE = 2'b11;
        Req = 1'b1;
        begin
            int g;
            g = 0;
            do begin
                @(negedge FCLK);
                g++;
            end while (!Busy && g < 20);
        end
        Req = 1'b0;
        chk("rst2 accept", {31'd0, Busy}, 32'd1);
        repeat (2) @(negedge FCLK);
        chk("rst2 inwait", {31'd0, bus.nAS}, 32'd0);
        Reset = 1'b1;
        @(negedge FCLK);
        Reset = 1'b0;
        m_rd = 16'h0;
        chk("rst2 nAS", {31'd0, bus.nAS}, 32'd1);
        chk("rst2 nUDS", {31'd0, bus.nUDS}, 32'd1);
        chk("rst2 nLDS", {31'd0, bus.nLDS}, 32'd1);
        chk("rst2 DOE", {31'd0, bus.DOE}, 32'd0);
        chk("rst2 Busy", {31'd0, Busy}, 32'd0);
        chk("rst2 RdData", {16'd0, RdData}, {16'd0, m_rd});
        repeat (6) begin
            chk("rst2 noDone", {31'd0, Done}, 32'd0);
            @(negedge FCLK);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
